// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a byte FIFO fed by a start/ready handshake,
// drained by a serializer that emits frames back to back with no idle gap.
module uart_tx_buffered #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [7:0]                    data_in,
  output logic                          ready,
  output logic                          TX,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_busy,
  output logic                          overflow
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W        = PTR_W + 1;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA      = 2'd2,
    STOP_BIT  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   baud_cnt_q, baud_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic               stop_cnt_q, stop_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               ready_q, ready_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         mem_q [FIFO_DEPTH];

  logic               push_c;
  logic               pop_c;
  logic               bit_done_c;
  logic               has_byte_c;

  // Next-state logic for the FIFO bookkeeping and the serializer
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pop_c      = 1'b0;

    push_c     = start && ready_q;
    has_byte_c = (level_q != '0);
    bit_done_c = (baud_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    unique case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        if (has_byte_c) begin
          pop_c   = 1'b1;
          state_d = START_BIT;
        end
      end
      START_BIT: begin
        if (bit_done_c) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_done_c) begin
          baud_cnt_d = '0;
          shift_d    = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            stop_cnt_d = 1'b0;
            state_d    = STOP_BIT;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      STOP_BIT: begin
        if (bit_done_c) begin
          baud_cnt_d = '0;
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            // Chain straight into the next start bit when more bytes wait
            if (has_byte_c) begin
              pop_c   = 1'b1;
              state_d = START_BIT;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop_c) begin
      shift_d  = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    level_d    = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
    ready_d    = (level_d < LVL_W'(FIFO_DEPTH));
    overflow_d = start && !ready_q;
    busy_d     = !((state_q == IDLE) && !has_byte_c);

    // Line value follows the state one cycle later so every bit is a full period
    unique case (state_q)
      START_BIT: tx_d = 1'b0;
      DATA:      tx_d = shift_q[0];
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ready_q    <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ready_q    <= ready_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  // Byte storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign ready      = ready_q;
  assign TX         = tx_q;
  assign fifo_level = level_q;
  assign tx_busy    = busy_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: directed scenarios plus a randomized
// run scored against a frame-level schedule model.
module tb_uart_tx_buffered;

  localparam int CPB   = 10;
  localparam int DEPTH = 16;
  localparam int FL1   = 10 * CPB;
  localparam int FL2   = 11 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start1 = 1'b0, start2 = 1'b0;
  logic [7:0] data1 = 8'h00, data2 = 8'h00;
  logic       ready1, ready2, tx1, tx2, busy1, busy2, ovf1, ovf2;
  logic [4:0] level1, level2;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int ovf_seen = 0;
  int burst_n0 = 0;

  typedef struct { logic [7:0] b; int t; bit ok; } frame_t;
  frame_t fq1[$];
  frame_t fq2[$];

  uart_tx_buffered #(.CLK_FREQ(1000000), .BAUD(100000), .FIFO_DEPTH(16), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .data_in(data1), .ready(ready1), .TX(tx1),
    .fifo_level(level1), .tx_busy(busy1), .overflow(ovf1));

  uart_tx_buffered #(.CLK_FREQ(1000000), .BAUD(100000), .FIFO_DEPTH(16), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .data_in(data2), .ready(ready2), .TX(tx2),
    .fifo_level(level2), .tx_busy(busy2), .overflow(ovf2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (ovf1 === 1'b1) ovf_seen <= ovf_seen + 1;

  function automatic logic tx_of(input int w);
    return (w == 0) ? tx1 : tx2;
  endfunction

  // Decode one frame whose start bit was first seen at the current negedge
  task automatic mon_frame(input int w);
    frame_t f;
    int     fl;
    bit     aborted;
    fl = (w == 0) ? FL1 : FL2;
    aborted = 1'b0;
    f.b = 8'h00; f.t = cyc; f.ok = 1'b1;
    for (int o = 1; o < fl && !aborted; o++) begin
      @(negedge clk);
      if (rst_n !== 1'b1) aborted = 1'b1;
      else if ((o % CPB) == CPB / 2) begin
        if (o < CPB) begin
          if (tx_of(w) !== 1'b0) f.ok = 1'b0;
        end else if (o < 9 * CPB) begin
          f.b[3'(o / CPB - 1)] = tx_of(w);
        end else if (tx_of(w) !== 1'b1) begin
          f.ok = 1'b0;
        end
      end
    end
    if (!aborted) begin
      if (w == 0) fq1.push_back(f);
      else fq2.push_back(f);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && tx1 === 1'b0) mon_frame(0);
  end

  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && tx2 === 1'b0) mon_frame(1);
  end

  task automatic test_reset();
    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx1 !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", tx1); end
    checks++; if (ready1 !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", ready1); end
    checks++; if (level1 !== 5'd0) begin failures++; $display("FAIL reset_level: got %0d expected 0", level1); end
    checks++; if (busy1 !== 1'b0 || ovf1 !== 1'b0) begin failures++; $display("FAIL reset_busy_ovf: got %b%b expected 00", busy1, ovf1); end
    rst_n = 1'b1;
    #1;
    checks++; if (ready1 !== 1'b0) begin failures++; $display("FAIL release_ready_early: got %b expected 0", ready1); end
    @(posedge clk); #1;
    checks++; if (ready1 !== 1'b1 || ready2 !== 1'b1) begin failures++; $display("FAIL release_ready: got %b%b expected 11", ready1, ready2); end
  endtask

  task automatic test_single();
    logic [7:0] v;
    int n, bad, badbusy, idx;
    logic e;
    v = 8'hA5; bad = 0; badbusy = 0;
    fq1.delete();
    @(negedge clk); start1 = 1'b1; data1 = v;
    @(negedge clk); start1 = 1'b0; n = cyc;
    checks++; if (level1 !== 5'd1 || tx1 !== 1'b1) begin failures++; $display("FAIL single_push: level %0d tx %b expected 1 1", level1, tx1); end
    @(negedge clk);
    checks++; if (tx1 !== 1'b1 || level1 !== 5'd0) begin failures++; $display("FAIL single_pop: tx %b level %0d expected 1 0", tx1, level1); end
    for (int c = 0; c < FL1; c++) begin
      @(negedge clk);
      idx = c / CPB;
      e = (idx == 0) ? 1'b0 : (idx <= 8) ? v[3'(idx - 1)] : 1'b1;
      if (tx1 !== e) bad++;
      if (busy1 !== 1'b1) badbusy++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL single_wave: got %0d wrong TX cycles expected 0", bad); end
    checks++; if (badbusy != 0) begin failures++; $display("FAIL single_busy: got %0d idle cycles expected 0", badbusy); end
    @(negedge clk);
    checks++; if (busy1 !== 1'b0 || tx1 !== 1'b1) begin failures++; $display("FAIL single_end: busy %b tx %b expected 0 1", busy1, tx1); end
    checks++;
    if (fq1.size() != 1 || fq1[0].b !== v || fq1[0].t != n + 2 || !fq1[0].ok) begin
      failures++; $display("FAIL single_frame: got %0d frames expected 1 at cycle %0d", fq1.size(), n + 2);
    end
  endtask

  task automatic test_burst();
    fq1.delete();
    for (int k = 0; k < 17; k++) begin
      @(negedge clk); start1 = 1'b1; data1 = 8'(k);
      @(negedge clk); start1 = 1'b0;
      if (k == 0) burst_n0 = cyc;
      checks++;
      if (level1 !== 5'((k == 0) ? 1 : k) || ready1 !== ((k < 16) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL burst_level_%0d: level %0d ready %b expected %0d %b", k, level1, ready1,
                             (k == 0) ? 1 : k, (k < 16));
      end
    end
  endtask

  task automatic test_overflow();
    start1 = 1'b1; data1 = 8'hFF;
    @(negedge clk); start1 = 1'b0;
    checks++; if (ovf1 !== 1'b1 || level1 !== 5'd16 || ready1 !== 1'b0) begin
      failures++; $display("FAIL ovf_pulse: ovf %b level %0d ready %b expected 1 16 0", ovf1, level1, ready1); end
    @(negedge clk);
    checks++; if (ovf1 !== 1'b0 || level1 !== 5'd16) begin
      failures++; $display("FAIL ovf_single_cycle: ovf %b level %0d expected 0 16", ovf1, level1); end
  endtask

  task automatic test_drain();
    int bad;
    bad = 0;
    for (int i = 0; i < 2500 && busy1 !== 1'b0; i++) @(negedge clk);
    checks++; if (busy1 !== 1'b0 || cyc != burst_n0 + 2 + 17 * FL1) begin
      failures++; $display("FAIL burst_total: busy fell at %0d expected %0d", cyc, burst_n0 + 2 + 17 * FL1); end
    checks++; if (fq1.size() != 17) begin failures++; $display("FAIL burst_count: got %0d expected 17", fq1.size()); end
    for (int k = 0; k < fq1.size() && k < 17; k++)
      if (fq1[k].b !== 8'(k) || fq1[k].t != burst_n0 + 2 + k * FL1 || !fq1[k].ok) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL burst_frames: got %0d bad frames expected 0", bad); end
  endtask

  task automatic test_handshake();
    logic [127:0] word;
    int idx, bad;
    word = 128'h0F0E0D0C0B0A09080706050403020100;
    idx = 0; bad = 0;
    fq1.delete();
    @(negedge clk); ovf_seen = 0;
    for (int i = 0; i < 200 && !(idx == 16 && !start1); i++) begin
      @(negedge clk);
      if (start1) start1 = 1'b0;
      else if (idx < 16 && ready1) begin start1 = 1'b1; data1 = word[idx * 8 +: 8]; idx++; end
    end
    for (int i = 0; i < 2500 && busy1 !== 1'b0; i++) @(negedge clk);
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL hs_timeout: busy %b expected 0", busy1); end
    checks++; if (fq1.size() != 16) begin failures++; $display("FAIL hs_count: got %0d expected 16", fq1.size()); end
    for (int k = 0; k < fq1.size() && k < 16; k++) if (fq1[k].b !== 8'(k) || !fq1[k].ok) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL hs_order: got %0d bad frames expected 0", bad); end
    checks++; if (ovf_seen != 0) begin failures++; $display("FAIL hs_overflow: got %0d pulses expected 0", ovf_seen); end
  endtask

  // Schedule model: a byte queued before edge e is popped at e once the previous
  // frame (popped at last_pop) has run its full length; its frame starts at e+1.
  task automatic test_random();
    logic [7:0] pend[$];
    frame_t     expf[$];
    frame_t     f;
    int last_pop, e, m_level, bad_rdy, bad_lvl, bad_ovf, bad_busy, fbad, first_bad;
    bit m_ready, m_ovf, m_busy, busy_next;
    last_pop = -100000; m_level = 0; m_ready = 1'b1; m_ovf = 1'b0; m_busy = 1'b0;
    bad_rdy = 0; bad_lvl = 0; bad_ovf = 0; bad_busy = 0; fbad = 0; first_bad = -1;
    fq1.delete();
    for (int k = 0; k < 2200; k++) begin
      @(negedge clk);
      if (ready1 !== m_ready) bad_rdy++;
      if (level1 !== 5'(m_level)) bad_lvl++;
      if (ovf1 !== m_ovf) bad_ovf++;
      if (busy1 !== m_busy) bad_busy++;
      if (first_bad < 0 && (ready1 !== m_ready || level1 !== 5'(m_level) || ovf1 !== m_ovf || busy1 !== m_busy))
        first_bad = cyc;
      start1 = (k < 400) ? ($urandom_range(99) < 55) : 1'b0;
      data1  = 8'($urandom);
      e = cyc + 1;
      busy_next = (last_pop + FL1 > e - 1) || (pend.size() != 0);
      if (pend.size() != 0 && e >= last_pop + FL1) begin
        f.b = pend.pop_front(); f.t = e + 1; f.ok = 1'b1;
        expf.push_back(f);
        last_pop = e;
      end
      m_ovf = start1 && !m_ready;
      if (start1 && m_ready) pend.push_back(data1);
      m_level = pend.size();
      m_ready = (m_level < DEPTH);
      m_busy  = busy_next;
    end
    checks++; if (bad_rdy != 0) begin failures++; $display("FAIL rand_ready: got %0d wrong cycles (first %0d) expected 0", bad_rdy, first_bad); end
    checks++; if (bad_lvl != 0) begin failures++; $display("FAIL rand_level: got %0d wrong cycles (first %0d) expected 0", bad_lvl, first_bad); end
    checks++; if (bad_ovf != 0) begin failures++; $display("FAIL rand_overflow: got %0d wrong cycles (first %0d) expected 0", bad_ovf, first_bad); end
    checks++; if (bad_busy != 0) begin failures++; $display("FAIL rand_busy: got %0d wrong cycles (first %0d) expected 0", bad_busy, first_bad); end
    checks++; if (fq1.size() != expf.size()) begin failures++; $display("FAIL rand_count: got %0d frames expected %0d", fq1.size(), expf.size()); end
    for (int i = 0; i < fq1.size() && i < expf.size(); i++)
      if (fq1[i].b !== expf[i].b || fq1[i].t != expf[i].t || !fq1[i].ok) fbad++;
    checks++; if (fbad != 0) begin failures++; $display("FAIL rand_frames: got %0d bad frames expected 0", fbad); end
  endtask

  task automatic test_stop2();
    logic [7:0] b0, b1, v;
    int n, bad, badbusy, o, idx;
    logic e;
    b0 = 8'($urandom); b1 = 8'($urandom); bad = 0; badbusy = 0;
    fq2.delete();
    @(negedge clk); start2 = 1'b1; data2 = b0;
    @(negedge clk); data2 = b1;
    @(negedge clk); start2 = 1'b0; n = cyc - 1;
    for (int c = 0; c < 2 * FL2; c++) begin
      @(negedge clk);
      o = c % FL2; idx = o / CPB; v = (c < FL2) ? b0 : b1;
      e = (idx == 0) ? 1'b0 : (idx <= 8) ? v[3'(idx - 1)] : 1'b1;
      if (tx2 !== e) bad++;
      if (busy2 !== 1'b1) badbusy++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL stop2_wave: got %0d wrong TX cycles expected 0", bad); end
    checks++; if (badbusy != 0) begin failures++; $display("FAIL stop2_busy: got %0d idle cycles expected 0", badbusy); end
    @(negedge clk);
    checks++; if (busy2 !== 1'b0 || level2 !== 5'd0 || ovf2 !== 1'b0) begin
      failures++; $display("FAIL stop2_end: busy %b level %0d ovf %b expected 0 0 0", busy2, level2, ovf2); end
    checks++;
    if (fq2.size() != 2 || fq2[0].b !== b0 || fq2[1].b !== b1 || fq2[0].t != n + 2 || fq2[1].t != n + 2 + FL2 || !fq2[1].ok) begin
      failures++; $display("FAIL stop2_frames: got %0d frames expected 2 at %0d and %0d", fq2.size(), n + 2, n + 2 + FL2);
    end
  endtask

  task automatic test_midframe_reset();
    logic [7:0] bb [5];
    int n, bad;
    bad = 0;
    for (int i = 0; i < 5; i++) bb[i] = 8'($urandom);
    bb[1] = bb[1] & 8'hF7;
    fq1.delete();
    @(negedge clk); start1 = 1'b1; data1 = bb[0];
    for (int i = 1; i < 5; i++) begin @(negedge clk); data1 = bb[i]; end
    @(negedge clk); start1 = 1'b0; n = cyc - 4;
    for (int i = 0; i < 400 && cyc < n + 146; i++) @(negedge clk);
    checks++; if (tx1 !== 1'b0) begin failures++; $display("FAIL mid_bit3: got %b expected 0", tx1); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx1 !== 1'b1 || level1 !== 5'd0 || ready1 !== 1'b0 || busy1 !== 1'b0) begin
      failures++; $display("FAIL mid_reset: tx %b level %0d ready %b busy %b expected 1 0 0 0", tx1, level1, ready1, busy1); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (ready1 !== 1'b0) begin failures++; $display("FAIL mid_release_early: got %b expected 0", ready1); end
    @(posedge clk); #1;
    checks++; if (ready1 !== 1'b1) begin failures++; $display("FAIL mid_release_ready: got %b expected 1", ready1); end
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || level1 !== 5'd0 || busy1 !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL mid_quiet: got %0d active cycles expected 0", bad); end
    checks++; if (fq1.size() != 1 || fq1[0].b !== bb[0]) begin
      failures++; $display("FAIL mid_frames: got %0d frames expected 1 with %h", fq1.size(), bb[0]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_drain();
    test_handshake();
    test_random();
    test_stop2();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
